// File: rtl/sha512_msg_feeder_pkg.sv
// sha512_msg_feeder_pkg: shared constants and feeder state type for the SHA-512 message feeder
package sha512_msg_feeder_pkg;
  localparam int WORD_W = 64;
  localparam int BLK_WORDS = 16;
  localparam int LEN_W = 64;
  localparam int LEN_WORD_HI = 14;
  localparam logic [63:0] PAD_MARKER = 64'h8000_0000_0000_0000;
  localparam logic [15:0] MODE_224 = 16'd224;
  localparam logic [15:0] MODE_256 = 16'd256;
  localparam logic [15:0] MODE_512 = 16'd512;
  typedef enum logic [2:0] {IDLE, FILL, PAD, SEND, WAIT} state_t;
endpackage

// File: rtl/sha512_pad_word.sv
// sha512_pad_word: keeps the first nbytes bytes of a big-endian word, inserts 0x80 after them and zeroes the rest
// Ports: data (message word), nbytes (valid bytes 0..8; 8 or more passes data through), word (padded word)
module sha512_pad_word
  import sha512_msg_feeder_pkg::*;
(
  input  logic [63:0] data,
  input  logic [3:0]  nbytes,
  output logic [63:0] word
);
  logic [5:0] sh;
  assign sh = {nbytes[2:0], 3'b000};
  assign word = nbytes[3] ? data : (data & ~({64{1'b1}} >> sh)) | (PAD_MARKER >> sh);
endmodule

// File: rtl/sha512_msg_feeder.sv
// sha512_msg_feeder: pads a 64-bit word message stream into 1024-bit SHA-512 blocks and hands them to the core one at a time
// Ports: clk/rst (async active-high); msg_* word stream in (valid/ready/data/last/bytes/mode);
//        blk_* block out (sync/ready/data/init/mode); core_done pulse from core; busy while a message is in progress
module sha512_msg_feeder
  import sha512_msg_feeder_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          msg_valid,
  output logic          msg_ready,
  input  logic [63:0]   msg_data,
  input  logic          msg_last,
  input  logic [3:0]    msg_bytes,
  input  logic [15:0]   msg_mode,
  output logic          blk_sync,
  input  logic          blk_ready,
  output logic [1023:0] blk_data,
  output logic          blk_init,
  output logic [15:0]   blk_mode,
  input  logic          core_done,
  output logic          busy
);
  state_t state, state_n;
  logic [WORD_W-1:0] words [BLK_WORDS];
  logic [4:0] idx;
  logic [LEN_W-1:0] byte_cnt;
  logic first_blk, marker_pend, msg_done, len_done;
  logic [63:0] pad_out;
  logic accept, blk_acc;
  sha512_pad_word u_pad (.data(msg_data), .nbytes(msg_bytes), .word(pad_out));
  assign accept = msg_valid && msg_ready;
  assign blk_acc = blk_sync && blk_ready;
  assign blk_init = first_blk;
  for (genvar g = 0; g < BLK_WORDS; g++) begin : g_pack
    assign blk_data[1023-64*g -: 64] = words[g];
  end
  always_comb begin
    msg_ready = !rst && (state == IDLE || state == FILL);
    blk_sync = state == SEND;
    busy = state != IDLE;
    state_n = state;
    case (state)
      IDLE, FILL: if (accept) state_n = msg_last ? PAD : (state == FILL && idx == 5'd15) ? SEND : FILL;
      // the length goes in once the marker is placed and slot 14 is reached; idx 16 means the block is full
      PAD: if (idx == 5'd16 || (idx == 5'(LEN_WORD_HI) && !marker_pend)) state_n = SEND;
      SEND: if (blk_acc) state_n = WAIT;
      WAIT: if (core_done) state_n = len_done ? IDLE : msg_done ? PAD : FILL;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      byte_cnt <= '0;
      first_blk <= 1'b0;
      marker_pend <= 1'b0;
      msg_done <= 1'b0;
      len_done <= 1'b0;
      blk_mode <= '0;
      for (int i = 0; i < BLK_WORDS; i++) words[i] <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        words[idx[3:0]] <= msg_last ? pad_out : msg_data;
        idx <= (state == IDLE) ? 5'd1 : idx + 5'd1;
        byte_cnt <= ((state == IDLE) ? '0 : byte_cnt) + (msg_last ? LEN_W'(msg_bytes) : LEN_W'(8));
        // a full final word leaves the marker for the next free slot, possibly in the next block
        marker_pend <= msg_last && msg_bytes >= 4'd8;
        msg_done <= msg_last;
        if (state == IDLE) begin
          blk_mode <= msg_mode;
          first_blk <= 1'b1;
          len_done <= 1'b0;
        end
      end
      if (state == PAD && idx != 5'd16) begin
        if (idx == 5'(LEN_WORD_HI) && !marker_pend) begin
          words[LEN_WORD_HI] <= '0;
          words[LEN_WORD_HI+1] <= byte_cnt << 3;
          len_done <= 1'b1;
        end else begin
          words[idx[3:0]] <= marker_pend ? PAD_MARKER : '0;
          marker_pend <= 1'b0;
          idx <= idx + 5'd1;
        end
      end
      if (blk_acc) first_blk <= 1'b0;
      if (state == WAIT && core_done) idx <= '0;
    end
  end
endmodule

// File: tb/tb_sha512_msg_feeder.sv
// tb_sha512_msg_feeder: directed scoreboard bench for the SHA-512 message feeder
module tb_sha512_msg_feeder;
  logic clk = 0, rst = 1, msg_valid = 0, msg_last = 0, blk_ready = 0, core_done = 0;
  logic [63:0] msg_data = '0;
  logic [3:0] msg_bytes = '0;
  logic [15:0] msg_mode = '0;
  logic msg_ready, blk_sync, blk_init, busy;
  logic [1023:0] blk_data;
  logic [15:0] blk_mode;
  typedef struct packed {logic [1023:0] data; logic init; logic [15:0] mode;} blk_t;
  blk_t sb[$];
  logic [63:0] ws[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  sha512_msg_feeder dut (
    .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .msg_last(msg_last), .msg_bytes(msg_bytes), .msg_mode(msg_mode), .blk_sync(blk_sync),
    .blk_ready(blk_ready), .blk_data(blk_data), .blk_init(blk_init), .blk_mode(blk_mode),
    .core_done(core_done), .busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push_msg(input logic [63:0] mw[$], input int nb, input logic [15:0] mode);
    logic [7:0] by[$];
    logic [63:0] w, lb;
    blk_t b;
    for (int i = 0; i < nb; i++) begin
      w = mw[i/8];
      by.push_back(w[63-8*(i%8) -: 8]);
    end
    by.push_back(8'h80);
    while (by.size() % 128 != 112) by.push_back(8'h00);
    lb = 64'(nb) * 64'd8;
    for (int j = 0; j < 8; j++) by.push_back(8'h00);
    for (int j = 7; j >= 0; j--) by.push_back(lb[8*j +: 8]);
    for (int k = 0; k < by.size() / 128; k++) begin
      b.data = '0;
      for (int j = 0; j < 128; j++) b.data[1023-8*j -: 8] = by[128*k+j];
      b.init = (k == 0);
      b.mode = mode;
      sb.push_back(b);
    end
  endtask
  task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
    bit ok = 0;
    msg_data = d;
    msg_last = last;
    msg_bytes = nb;
    msg_valid = 1;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = msg_ready;
    end
    if (!ok) chk("ready_timeout", 64'(msg_ready), 64'd1);
    @(posedge clk);
    #1;
    msg_valid = 0;
    msg_last = 0;
  endtask
  task automatic chk_blk(input string tag, input blk_t e);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_w%0d", tag, i), blk_data[1023-64*i -: 64], e.data[1023-64*i -: 64]);
    chk({tag, "_init"}, 64'(blk_init), 64'(e.init));
    chk({tag, "_mode"}, 64'(blk_mode), 64'(e.mode));
  endtask
  task automatic take_block(input int hold);
    blk_t e;
    bit ok = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = blk_sync;
    end
    e = sb.pop_front();
    if (!ok) begin
      chk("sync_timeout", 64'(blk_sync), 64'd1);
      @(posedge clk);
      #1;
      return;
    end
    chk_blk("blk", e);
    chk("send_rdy", 64'(msg_ready), 64'd0);
    chk("send_busy", 64'(busy), 64'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      core_done = (h == 4);
    end
    if (hold > 0) begin
      core_done = 0;
      @(negedge clk);
      chk("hold_sync", 64'(blk_sync), 64'd1);
      chk_blk("hold", e);
    end
    blk_ready = 1;
    core_done = 1;
    @(negedge clk);
    blk_ready = 0;
    core_done = 0;
    chk("sync_drop", 64'(blk_sync), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("wait_rdy", 64'(msg_ready), 64'd0);
      chk("wait_sync", 64'(blk_sync), 64'd0);
    end
    core_done = 1;
    @(negedge clk);
    core_done = 0;
    @(posedge clk);
    #1;
  endtask
  task automatic run_msg(input logic [63:0] mw[$], input int nb, input logic [15:0] mode, input int hold);
    int nw;
    push_msg(mw, nb, mode);
    nw = mw.size();
    msg_mode = mode;
    for (int i = 0; i < nw; i++) begin
      send_word(mw[i], i == nw - 1, (i == nw - 1) ? 4'(nb - 8 * (nw - 1)) : 4'd0);
      if (i != nw - 1 && i % 16 == 15) take_block(hold);
    end
    while (sb.size() > 0) take_block(hold);
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_rdy", 64'(msg_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask
  task automatic rand_words(input int n);
    ws.delete();
    for (int i = 0; i < n; i++) ws.push_back({$urandom, $urandom});
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 64'(msg_ready), 64'd0);
    chk("rst_sync", 64'(blk_sync), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_init", 64'(blk_init), 64'd0);
    chk("rst_mode", 64'(blk_mode), 64'd0);
    chk("rst_data", blk_data[1023:960], 64'd0);
    @(posedge clk);
    #1;
    rst = 0;
    ws = '{64'h6162_6300_0000_0000};
    run_msg(ws, 3, 16'd512, 10);
    rand_words(14);
    run_msg(ws, 112, 16'd256, 0);
    ws = '{64'h0123_4567_89ab_cdef};
    run_msg(ws, 0, 16'd224, 0);
    rand_words(17);
    run_msg(ws, 136, 16'd512, 0);
    rand_words(16);
    run_msg(ws, 128, 16'h1234, 0);
    rand_words(15);
    run_msg(ws, 117, 16'd384, 0);
    rand_words(3);
    run_msg(ws, 21, 16'd512, 3);
    msg_mode = 16'd512;
    send_word(64'hdead_beef_cafe_f00d, 1, 4'd3);
    repeat (3) @(negedge clk);
    chk("pad_busy", 64'(busy), 64'd1);
    chk("pad_rdy", 64'(msg_ready), 64'd0);
    rst = 1;
    #1;
    chk("mrst_rdy", 64'(msg_ready), 64'd0);
    chk("mrst_sync", 64'(blk_sync), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_init", 64'(blk_init), 64'd0);
    chk("mrst_mode", 64'(blk_mode), 64'd0);
    for (int i = 0; i < 16; i++) chk($sformatf("mrst_w%0d", i), blk_data[1023-64*i -: 64], 64'd0);
    @(posedge clk);
    #1;
    rst = 0;
    ws = '{64'h6162_6300_0000_0000};
    run_msg(ws, 3, 16'd512, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
